// File: rtl/parking_occupancy_ctrl_if.sv
// Sensor/status bundle for parking_occupancy_ctrl: per-lane beam inputs in, event pulses and occupancy out.
interface parking_occupancy_ctrl_if #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CW    = 8
);
  logic [LANES-1:0] a;
  logic [LANES-1:0] b;
  logic             clr_err;
  logic [LANES-1:0] enter;
  logic [LANES-1:0] exit;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic             ovf;
  logic             unf;

  modport master (
    output a, b, clr_err,
    input  enter, exit, count, full, empty, ovf, unf
  );

  modport slave (
    input  a, b, clr_err,
    output enter, exit, count, full, empty, ovf, unf
  );
endinterface

// File: rtl/parking_occupancy_ctrl.sv
// Multi-lane beam-pair entry/exit classifier with a saturating shared occupancy counter.
// Optional PARK_SYNC_EN adds a 2-flop synchroniser on every sensor input (+2 cycles latency).
module parking_occupancy_ctrl #(
  parameter int unsigned LANES = 2,
  parameter int unsigned CAP   = 100,
  parameter int unsigned CW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  parking_occupancy_ctrl_if.slave bus
);

  localparam int unsigned SW = CW + 4;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_EN1  = 3'd1;
  localparam logic [2:0] ST_EN2  = 3'd2;
  localparam logic [2:0] ST_EN3  = 3'd3;
  localparam logic [2:0] ST_EX1  = 3'd4;
  localparam logic [2:0] ST_EX2  = 3'd5;
  localparam logic [2:0] ST_EX3  = 3'd6;

  logic [LANES-1:0] a_c;
  logic [LANES-1:0] b_c;

`ifdef PARK_SYNC_EN
  logic [LANES-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q <= '0;
      a_s2_q <= '0;
      b_s1_q <= '0;
      b_s2_q <= '0;
    end else begin
      a_s1_q <= bus.a;
      a_s2_q <= a_s1_q;
      b_s1_q <= bus.b;
      b_s2_q <= b_s1_q;
    end
  end

  assign a_c = a_s2_q;
  assign b_c = b_s2_q;
`else
  assign a_c = bus.a;
  assign b_c = bus.b;
`endif

  logic [2:0]       state_q [LANES];
  logic [2:0]       state_d [LANES];
  logic [LANES-1:0] enter_q, enter_d;
  logic [LANES-1:0] exit_q, exit_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Per-lane direction FSM; EX states mirror EN states with a/b swapped.
  always_comb begin
    enter_d = '0;
    exit_d  = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if ({a_c[i], b_c[i]} == 2'b10)      state_d[i] = ST_EN1;
          else if ({a_c[i], b_c[i]} == 2'b01) state_d[i] = ST_EX1;
        end
        ST_EN1: begin
          if ({a_c[i], b_c[i]} == 2'b11)      state_d[i] = ST_EN2;
          else if ({a_c[i], b_c[i]} != 2'b10) state_d[i] = ST_IDLE;
        end
        ST_EN2: begin
          case ({a_c[i], b_c[i]})
            2'b01:   state_d[i] = ST_EN3;
            2'b10:   state_d[i] = ST_EN1;
            2'b00:   state_d[i] = ST_IDLE;
            default: state_d[i] = ST_EN2;
          endcase
        end
        ST_EN3: begin
          case ({a_c[i], b_c[i]})
            2'b11:   state_d[i] = ST_EN2;
            2'b00: begin
              state_d[i] = ST_IDLE;
              enter_d[i] = 1'b1;
            end
            2'b10:   state_d[i] = ST_IDLE;
            default: state_d[i] = ST_EN3;
          endcase
        end
        ST_EX1: begin
          if ({a_c[i], b_c[i]} == 2'b11)      state_d[i] = ST_EX2;
          else if ({a_c[i], b_c[i]} != 2'b01) state_d[i] = ST_IDLE;
        end
        ST_EX2: begin
          case ({a_c[i], b_c[i]})
            2'b10:   state_d[i] = ST_EX3;
            2'b01:   state_d[i] = ST_EX1;
            2'b00:   state_d[i] = ST_IDLE;
            default: state_d[i] = ST_EX2;
          endcase
        end
        ST_EX3: begin
          case ({a_c[i], b_c[i]})
            2'b11:   state_d[i] = ST_EX2;
            2'b00: begin
              state_d[i] = ST_IDLE;
              exit_d[i]  = 1'b1;
            end
            2'b01:   state_d[i] = ST_IDLE;
            default: state_d[i] = ST_EX3;
          endcase
        end
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  logic [3:0]           ne_c, nx_c;
  logic signed [SW-1:0] sum_c;

  // Net all lane events first, then clamp to [0, CAP] in widened signed arithmetic.
  always_comb begin
    ne_c = '0;
    nx_c = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      ne_c = ne_c + 4'(enter_d[i]);
      nx_c = nx_c + 4'(exit_d[i]);
    end
    sum_c   = $signed(SW'(count_q)) + $signed(SW'(ne_c)) - $signed(SW'(nx_c));
    count_d = CW'(sum_c);
    ovf_d   = ovf_q & ~bus.clr_err;
    unf_d   = unf_q & ~bus.clr_err;
    if (sum_c > $signed(SW'(CAP))) begin
      count_d = CW'(CAP);
      ovf_d   = 1'b1;
    end else if (sum_c < $signed(SW'(0))) begin
      count_d = '0;
      unf_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(LANES); i++) state_q[i] <= ST_IDLE;
      enter_q <= '0;
      exit_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      for (int i = 0; i < int'(LANES); i++) state_q[i] <= state_d[i];
      enter_q <= enter_d;
      exit_q  <= exit_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.enter = enter_q;
  assign bus.exit  = exit_q;
  assign bus.count = count_q;
  assign bus.full  = (count_q == CW'(CAP));
  assign bus.empty = (count_q == '0);
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// Directed bench for parking_occupancy_ctrl with LANES=2, CAP=3, CW=8.
module tb_parking_occupancy_ctrl;

`ifdef PARK_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  parking_occupancy_ctrl_if #(.LANES(2), .CW(8)) bus ();

  parking_occupancy_ctrl #(.LANES(2), .CAP(3), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drive one sampled edge: l0/l1 are {a,b} for lane 0 and lane 1.
  task automatic cyc(input logic [1:0] l0, input logic [1:0] l1, input logic clr);
    bus.a       = {l1[1], l0[1]};
    bus.b       = {l1[0], l0[0]};
    bus.clr_err = clr;
    @(posedge clk);
    #1;
  endtask

  // Four phases per lane, then idle until the pulse lands; clr_err rides the counting edge if asked.
  task automatic run4(input logic [7:0] p0, input logic [7:0] p1, input logic clr_last);
    int total;
    total = 4 + SYNC_LAT;
    for (int k = 0; k < total; k++) begin
      if (k < 4) cyc(p0[(3-k)*2 +: 2], p1[(3-k)*2 +: 2], clr_last && (k == total - 1));
      else       cyc(2'b00, 2'b00, clr_last && (k == total - 1));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
    chk({tag, "_full"},  32'(bus.full),  32'd0);
    chk({tag, "_ovf"},   32'(bus.ovf),   32'd0);
    chk({tag, "_unf"},   32'(bus.unf),   32'd0);
    chk({tag, "_enter"}, 32'(bus.enter), 32'd0);
    chk({tag, "_exit"},  32'(bus.exit),  32'd0);
  endtask

  localparam logic [7:0] ENTRY   = 8'b10_11_01_00;
  localparam logic [7:0] EXIT    = 8'b01_11_10_00;
  localparam logic [7:0] BACKOUT = 8'b10_11_10_00;
  localparam logic [7:0] QUIET   = 8'b00_00_00_00;

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_state("rst");
    rst_n = 1'b1;
    cyc(2'b00, 2'b00, 1'b0);

    // Single entry on lane 0
    run4(ENTRY, QUIET, 1'b0);
    chk("ent_pulse", 32'(bus.enter), 32'd1);
    chk("ent_count", 32'(bus.count), 32'd1);
    chk("ent_empty", 32'(bus.empty), 32'd0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("ent_drop", 32'(bus.enter), 32'd0);

    // Exit on lane 1, then an exit at zero
    run4(QUIET, EXIT, 1'b0);
    chk("ex_pulse", 32'(bus.exit), 32'd2);
    chk("ex_count", 32'(bus.count), 32'd0);
    chk("ex_empty", 32'(bus.empty), 32'd1);
    cyc(2'b00, 2'b00, 1'b0);
    chk("ex_drop", 32'(bus.exit), 32'd0);
    run4(QUIET, EXIT, 1'b0);
    chk("unf_count", 32'(bus.count), 32'd0);
    chk("unf_set", 32'(bus.unf), 32'd1);
    cyc(2'b00, 2'b00, 1'b1);
    chk("unf_clr", 32'(bus.unf), 32'd0);

    // Back-out sequence never counts
    run4(BACKOUT, QUIET, 1'b0);
    chk("bo_enter", 32'(bus.enter), 32'd0);
    cyc(2'b00, 2'b00, 1'b0);
    chk("bo_enter2", 32'(bus.enter), 32'd0);
    chk("bo_count", 32'(bus.count), 32'd0);

    // Fill to capacity: two parallel entries then one more
    run4(ENTRY, ENTRY, 1'b0);
    chk("par_pulse", 32'(bus.enter), 32'd3);
    chk("par_count", 32'(bus.count), 32'd2);
    run4(ENTRY, QUIET, 1'b0);
    chk("cap_count", 32'(bus.count), 32'd3);
    chk("cap_full", 32'(bus.full), 32'd1);

    // Entry and exit on the same edge net out at capacity
    run4(ENTRY, EXIT, 1'b0);
    chk("net_enter", 32'(bus.enter), 32'd1);
    chk("net_exit", 32'(bus.exit), 32'd2);
    chk("net_count", 32'(bus.count), 32'd3);
    chk("net_ovf", 32'(bus.ovf), 32'd0);
    run4(ENTRY, QUIET, 1'b0);
    chk("ovf_count", 32'(bus.count), 32'd3);
    chk("ovf_set", 32'(bus.ovf), 32'd1);
    chk("ovf_full", 32'(bus.full), 32'd1);

    // Down to 2, then reset with lane 0 parked in EN2
    run4(QUIET, EXIT, 1'b0);
    chk("pre_rst_count", 32'(bus.count), 32'd2);
    chk("pre_rst_full", 32'(bus.full), 32'd0);
    cyc(2'b10, 2'b00, 1'b0);
    cyc(2'b11, 2'b00, 1'b0);
    for (int k = 0; k < SYNC_LAT; k++) cyc(2'b11, 2'b00, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    bus.a = '0;
    bus.b = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(2'b01, 2'b00, 1'b0);
    cyc(2'b00, 2'b00, 1'b0);
    for (int k = 0; k < SYNC_LAT + 1; k++) begin
      cyc(2'b00, 2'b00, 1'b0);
      chk("post_rst_enter", 32'(bus.enter), 32'd0);
      chk("post_rst_exit",  32'(bus.exit),  32'd0);
    end
    chk("post_rst_count", 32'(bus.count), 32'd0);

    // clr_err on the same edge as a new underflow: flag stays set
    run4(QUIET, EXIT, 1'b1);
    chk("setwin_unf", 32'(bus.unf), 32'd1);
    cyc(2'b00, 2'b00, 1'b1);
    chk("setwin_clr", 32'(bus.unf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
